// File: rtl/elliptic_curve_structs.sv
`default_nettype none
//------------------------------------------------------------------------------
// elliptic_curve_structs -- field constants and mod_reduce_pipe FSM type. Rev 1.0
//------------------------------------------------------------------------------
package elliptic_curve_structs;

  localparam int unsigned P_WIDTH = 256;

  // secp256k1 base field: P = 2^256 - c with c = 2^32 + 977.
  localparam logic [P_WIDTH-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  // With c^2 < P, floor(2^512 / P) is exactly 2^256 + c.
  localparam logic [P_WIDTH:0] MU = {1'b1, 192'h0, 64'h00000001_000003D1};

  typedef enum logic [2:0] {
    MRP_IDLE = 3'd0,
    MRP_Q    = 3'd1,
    MRP_R    = 3'd2,
    MRP_C1   = 3'd3,
    MRP_C2   = 3'd4,
    MRP_HOLD = 3'd5
  } mrp_state_e;

endpackage
`default_nettype wire

// File: rtl/mod_cond_sub.sv
`default_nettype none
//------------------------------------------------------------------------------
// mod_cond_sub -- one Barrett correction step: r >= M ? r - M : r.   Rev 1.0
//------------------------------------------------------------------------------
module mod_cond_sub #(
  parameter int unsigned      WIDTH   = 10,
  parameter logic [WIDTH-1:0] MODULUS = '1
) (
  input  logic [WIDTH-1:0] r_i,
  output logic [WIDTH-1:0] r_o
);

  assign r_o = (r_i >= MODULUS) ? (r_i - MODULUS) : r_i;

endmodule
`default_nettype wire

// File: rtl/mod_reduce_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// mod_reduce_pipe -- handshaked Barrett reduction of a 2k-bit value mod P. Rev 1.0
//------------------------------------------------------------------------------
module mod_reduce_pipe #(
  parameter int unsigned        P_WIDTH  = elliptic_curve_structs::P_WIDTH,
  parameter logic [P_WIDTH-1:0] P        = elliptic_curve_structs::P,
  parameter logic [P_WIDTH:0]   MU       = elliptic_curve_structs::MU,
  parameter int unsigned        ID_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*P_WIDTH-1:0]   in_a,
  input  logic [ID_WIDTH-1:0]    in_id,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [P_WIDTH-1:0]     out_r,
  output logic [ID_WIDTH-1:0]    out_id,
  output logic                   busy
);
  import elliptic_curve_structs::*;

  localparam int unsigned RW = P_WIDTH + 2;

  mrp_state_e           state_q, state_d;
  logic [2*P_WIDTH-1:0] a_q, a_d;
  logic [P_WIDTH:0]     q_q, q_d;
  logic [RW-1:0]        r_q, r_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;

  logic [P_WIDTH:0]     a_hi;
  logic [2*P_WIDTH+1:0] q_prod;
  logic [P_WIDTH:0]     q_next;
  logic [RW-1:0]        qp_lo;
  logic [RW-1:0]        r_sub;

  assign a_hi   = a_q[2*P_WIDTH-1:P_WIDTH-1];
  assign q_prod = {{(P_WIDTH+1){1'b0}}, a_hi} * {{(P_WIDTH+1){1'b0}}, MU};
  assign q_next = (P_WIDTH+1)'(q_prod >> (P_WIDTH+1));
  // Only the low RW bits of q*P matter; the subtraction below wraps on purpose.
  assign qp_lo  = {1'b0, q_q} * {2'b00, P};

  mod_cond_sub #(
    .WIDTH   (RW),
    .MODULUS ({2'b00, P})
  ) u_cond_sub (
    .r_i (r_q),
    .r_o (r_sub)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    r_d     = r_q;
    id_d    = id_q;
    case (state_q)
      MRP_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          id_d    = in_id;
          state_d = MRP_Q;
        end
      end
      MRP_Q: begin
        q_d     = q_next;
        state_d = MRP_R;
      end
      MRP_R: begin
        r_d     = a_q[RW-1:0] - qp_lo;
        state_d = MRP_C1;
      end
      MRP_C1: begin
        r_d     = r_sub;
        state_d = MRP_C2;
      end
      MRP_C2: begin
        r_d     = r_sub;
        state_d = MRP_HOLD;
      end
      MRP_HOLD: begin
        if (out_ready) begin
          state_d = MRP_IDLE;
        end
      end
      default: state_d = MRP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MRP_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      r_q     <= r_d;
      id_q    <= id_d;
    end
  end

  assign in_ready  = (state_q == MRP_IDLE);
  assign out_valid = (state_q == MRP_HOLD);
  assign busy      = (state_q != MRP_IDLE);
  assign out_r     = r_q[P_WIDTH-1:0];
  assign out_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_reduce_pipe.sv
`default_nettype none
// Bench for mod_reduce_pipe: a P=13 instance for directed corners plus the
// default 256-bit instance under random traffic, both against a reference model.
module tb_mod_reduce_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // small instance (P_WIDTH=4, P=13)
  logic       s_rst, s_vld, s_rdy;
  logic [7:0] s_a;
  logic [3:0] s_id;
  logic       s_in_ready, s_out_valid, s_busy;
  logic [3:0] s_out_r, s_out_id;

  // default instance (P_WIDTH=256)
  logic         l_rst, l_vld, l_rdy;
  logic [511:0] l_a;
  logic [3:0]   l_id;
  logic         l_in_ready, l_out_valid, l_busy;
  logic [255:0] l_out_r;
  logic [3:0]   l_out_id;

  mod_reduce_pipe #(.P_WIDTH(4), .P(4'd13), .MU(5'd19), .ID_WIDTH(4)) dut_s (
    .clk(clk), .reset(s_rst), .in_valid(s_vld), .in_ready(s_in_ready),
    .in_a(s_a), .in_id(s_id), .out_valid(s_out_valid), .out_ready(s_rdy),
    .out_r(s_out_r), .out_id(s_out_id), .busy(s_busy)
  );

  mod_reduce_pipe dut_l (
    .clk(clk), .reset(l_rst), .in_valid(l_vld), .in_ready(l_in_ready),
    .in_a(l_a), .in_id(l_id), .out_valid(l_out_valid), .out_ready(l_rdy),
    .out_r(l_out_r), .out_id(l_out_id), .busy(l_busy)
  );

  // Reference model: a request is pending from its accept edge until the edge
  // on which out_ready is seen with the result visible; the result becomes
  // visible after the 4th edge following the accept edge.
  bit           m_pend [2];
  int           m_age  [2];
  bit           m_rstd [2];
  logic [255:0] m_r    [2];
  logic [3:0]   m_id   [2];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    chk(nm, {255'b0, act}, {255'b0, req});
  endtask

  task automatic model_step(input int s, input logic r, input logic v, input logic o,
                            input logic [511:0] av, input logic [3:0] iv,
                            input logic [255:0] m);
    if (r) begin
      m_pend[s] = 1'b0;
      m_age[s]  = 0;
      m_rstd[s] = 1'b1;
    end else begin
      m_rstd[s] = 1'b0;
      if (!m_pend[s]) begin
        if (v) begin
          m_pend[s] = 1'b1;
          m_age[s]  = 0;
          m_r[s]    = 256'(av % {256'b0, m});
          m_id[s]   = iv;
        end
      end else if (m_age[s] >= 4) begin
        if (o) m_pend[s] = 1'b0;
      end else begin
        m_age[s]++;
      end
    end
  endtask

  task automatic compare(input int s, input logic ir, input logic ov, input logic bz,
                         input logic [255:0] r, input logic [3:0] oid, input logic o,
                         input logic [255:0] m);
    string t;
    logic  exp_v;
    t     = (s == 0) ? "s" : "l";
    exp_v = m_pend[s] && (m_age[s] >= 4);
    chk1({t, " in_ready"}, ir, !m_pend[s]);
    chk1({t, " out_valid"}, ov, exp_v);
    chk1({t, " busy"}, bz, m_pend[s]);
    if (exp_v && ov) begin
      chk({t, " out_r"}, r, m_r[s]);
      chk({t, " out_id"}, {252'b0, oid}, {252'b0, m_id[s]});
      if (o) chk1({t, " out_r<P at handshake"}, r < m, 1'b1);
    end
    if (m_rstd[s]) begin
      chk({t, " out_r after reset"}, r, 256'd0);
      chk({t, " out_id after reset"}, {252'b0, oid}, 256'd0);
    end
  endtask

  always @(posedge clk) begin
    model_step(0, s_rst, s_vld, s_rdy, {504'b0, s_a}, s_id, 256'd13);
    model_step(1, l_rst, l_vld, l_rdy, l_a, l_id, elliptic_curve_structs::P);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      compare(0, s_in_ready, s_out_valid, s_busy, {252'b0, s_out_r}, s_out_id, s_rdy, 256'd13);
      compare(1, l_in_ready, l_out_valid, l_busy, l_out_r, l_out_id, l_rdy,
              elliptic_curve_structs::P);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One small-instance request with out_ready held high; literal result pins.
  task automatic s_req(input logic [7:0] av, input logic [3:0] iv,
                       input logic [3:0] exp_r, input string nm);
    int guard;
    int n;
    s_a = av; s_id = iv; s_vld = 1'b1; s_rdy = 1'b1;
    guard = 0;
    while (!s_in_ready && guard < 20) begin tick(); guard++; end
    chk1({nm, " accept wait"}, guard < 20, 1'b1);
    tick();
    s_vld = 1'b0;
    n = 1;
    while (!s_out_valid && n < 20) begin tick(); n++; end
    chk({nm, " latency edges"}, 256'(n), 256'd5);
    chk({nm, " out_r"}, {252'b0, s_out_r}, {252'b0, exp_r});
    chk({nm, " out_id"}, {252'b0, s_out_id}, {252'b0, iv});
    chk({nm, " model r"}, m_r[0], {252'b0, exp_r});
    tick();
    chk1({nm, " in_ready after handshake"}, s_in_ready, 1'b1);
    chk1({nm, " out_valid dropped"}, s_out_valid, 1'b0);
  endtask

  task automatic small_seq();
    int guard;
    int n;
    s_req(8'd168, 4'd3, 4'd12, "single");
    s_req(8'd0,   4'd1, 4'd0,  "a=0");
    s_req(8'd12,  4'd2, 4'd12, "a=12");
    s_req(8'd13,  4'd4, 4'd0,  "a=13");
    s_req(8'd144, 4'd6, 4'd1,  "a=144");
    s_req(8'd255, 4'd7, 4'd8,  "a=255");

    // backpressure with a stray request during the stall
    s_rdy = 1'b0; s_a = 8'd100; s_id = 4'd5; s_vld = 1'b1;
    guard = 0;
    while (!s_in_ready && guard < 20) begin tick(); guard++; end
    tick();
    s_vld = 1'b0;
    n = 1;
    while (!s_out_valid && n < 20) begin tick(); n++; end
    chk1("bp out_valid", s_out_valid, 1'b1);
    for (int c = 0; c < 7; c++) begin
      chk("bp out_r", {252'b0, s_out_r}, 256'd9);
      chk("bp out_id", {252'b0, s_out_id}, 256'd5);
      chk1("bp in_ready", s_in_ready, 1'b0);
      chk1("bp busy", s_busy, 1'b1);
      if (c == 2) begin s_vld = 1'b1; s_a = 8'd7; s_id = 4'd9; end
      if (c == 4) s_vld = 1'b0;
      tick();
    end
    s_rdy = 1'b1;
    tick();
    chk1("bp valid drop", s_out_valid, 1'b0);
    chk1("bp in_ready back", s_in_ready, 1'b1);
    tick();
    chk1("bp single handshake", s_out_valid, 1'b0);

    // reset while in R
    s_a = 8'd200; s_id = 4'd8; s_vld = 1'b1;
    tick();
    s_vld = 1'b0;
    tick();
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk1("mid-reset no output", s_out_valid, 1'b0);
      tick();
    end
    s_req(8'd50, 4'd2, 4'd11, "after reset");

    for (int i = 0; i < 300; i++) begin
      s_a = 8'($urandom_range(0, 255)); s_id = 4'(i); s_vld = 1'b1;
      guard = 0;
      while (!s_in_ready && guard < 64) begin
        s_rdy = ($urandom_range(0, 3) != 0);
        tick();
        guard++;
      end
      chk1("s random accept wait", guard < 64, 1'b1);
      tick();
      s_vld = 1'b0;
    end
    s_rdy = 1'b1;
    repeat (8) tick();
  endtask

  task automatic large_seq();
    int guard;
    for (int i = 0; i < 10000; i++) begin
      for (int j = 0; j < 16; j++) l_a[j*32 +: 32] = $urandom();
      if (i == 0) l_a = '1;
      else if (i == 1) l_a = '0;
      else if (i == 2) l_a = {256'b0, elliptic_curve_structs::P};
      else if (i == 3) l_a = {elliptic_curve_structs::P - 256'd1, {256{1'b1}}};
      l_id = 4'(i); l_vld = 1'b1;
      guard = 0;
      while (!l_in_ready && guard < 64) begin
        l_rdy = ($urandom_range(0, 3) != 0);
        tick();
        guard++;
      end
      chk1("l random accept wait", guard < 64, 1'b1);
      tick();
      l_vld = 1'b0;
      if (i == 1) chk("l model 0 mod P", m_r[1], 256'd0);
      if (i == 2) chk("l model P mod P", m_r[1], 256'd0);
    end
    l_rdy = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    s_rst = 1'b1; s_vld = 1'b0; s_rdy = 1'b1; s_a = '0; s_id = '0;
    l_rst = 1'b1; l_vld = 1'b0; l_rdy = 1'b1; l_a = '0; l_id = '0;
    repeat (3) tick();
    chk_on = 1'b1;
    chk1("reset in_ready", s_in_ready, 1'b1);
    chk1("reset out_valid", s_out_valid, 1'b0);
    chk1("reset busy", s_busy, 1'b0);
    chk("reset out_r", {252'b0, s_out_r}, 256'd0);
    chk("reset out_id", {252'b0, s_out_id}, 256'd0);
    s_rst = 1'b0;
    l_rst = 1'b0;
    fork
      small_seq();
      large_seq();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
